rx_sync_controller: RTL

RX_SYNC_CONTROLLER -- requirements
Module: rx_sync_controller

---
 rtl/rx_ctrl_pkg.sv | 33 +++
 rtl/rx_sync_controller_symbol_timer.sv | 60 ++++++
 rtl/rx_sync_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the receive-side acquisition controller: core parameter
// defaults, the controller state encoding and the derived cycle counts.
package rx_ctrl_pkg;

    localparam int WAVELENGTH_DEF      = 16;
    localparam int PREAMBLE_LENGTH_DEF = 8;
    localparam int FRAME_BITS_DEF      = 32;
    localparam int LOCK_HOLD_DEF       = 2;
    localparam int SEARCH_TIMEOUT_DEF  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_ALIGN   = 3'd3,
        ST_RECEIVE = 3'd4,
        ST_DONE    = 3'd5
    } rx_state_e;

    // The correlator must see a full preamble's worth of samples plus pipeline slack.
    function automatic int flush_cycles(input int wavelength, input int preamble_length);
        return wavelength * preamble_length + 4;
    endfunction

    function automatic int align_cycles(input int wavelength, input int lock_hold);
        return (wavelength > lock_hold) ? (wavelength - lock_hold) : 1;
    endfunction

    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/rx_sync_controller_symbol_timer.sv
// Per-symbol sample counter and symbol index counter; strobes at mid-symbol and
// flags the final sample of the final symbol.
module symbol_timer
    import rx_ctrl_pkg::*;
#(
    parameter int WAVELENGTH = WAVELENGTH_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          run,
    output logic                          strobe,
    output logic [$clog2(FRAME_BITS)-1:0] index,
    output logic                          last
);

    localparam int SAMPLE_W = cnt_width(WAVELENGTH - 1);
    localparam int IDX_W    = $clog2(FRAME_BITS);

    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(WAVELENGTH - 1);
    localparam logic [SAMPLE_W-1:0] PRE_MID     = SAMPLE_W'(WAVELENGTH / 2 - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(FRAME_BITS - 1);

    logic [SAMPLE_W-1:0] sample_cnt_r;
    logic [IDX_W-1:0]    index_r;
    logic                strobe_r;

    // Sample/symbol counting; strobe is registered so it rises as the count reaches mid-symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_r <= {SAMPLE_W{1'b0}};
            index_r      <= {IDX_W{1'b0}};
            strobe_r     <= 1'b0;
        end else if (clear) begin
            sample_cnt_r <= {SAMPLE_W{1'b0}};
            index_r      <= {IDX_W{1'b0}};
            strobe_r     <= 1'b0;
        end else if (run) begin
            strobe_r <= (sample_cnt_r == PRE_MID);
            if (sample_cnt_r == SAMPLE_LAST) begin
                sample_cnt_r <= {SAMPLE_W{1'b0}};
                // The final wrap is consumed by the controller, so the index saturates.
                index_r      <= (index_r == IDX_LAST) ? index_r : index_r + IDX_W'(1);
            end else begin
                sample_cnt_r <= sample_cnt_r + SAMPLE_W'(1);
                index_r      <= index_r;
            end
        end else begin
            strobe_r     <= 1'b0;
            sample_cnt_r <= sample_cnt_r;
            index_r      <= index_r;
        end
    end

    assign last   = (sample_cnt_r == SAMPLE_LAST) && (index_r == IDX_LAST);
    assign strobe = strobe_r;
    assign index  = index_r;

endmodule

// File: rtl/rx_sync_controller.sv
// Receiver acquisition controller: flushes the correlator, searches for a stable
// lock, aligns to mid-symbol and strobes out one frame of payload symbols.
module rx_sync_controller
    import rx_ctrl_pkg::*;
#(
    parameter int WAVELENGTH      = WAVELENGTH_DEF,
    parameter int PREAMBLE_LENGTH = PREAMBLE_LENGTH_DEF,
    parameter int FRAME_BITS      = FRAME_BITS_DEF,
    parameter int LOCK_HOLD       = LOCK_HOLD_DEF,
    parameter int SEARCH_TIMEOUT  = SEARCH_TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          corr_done,
    output logic                          corr_rst_n,
    output logic                          demod_en,
    output logic                          bit_strobe,
    output logic [$clog2(FRAME_BITS)-1:0] bit_index,
    output logic                          frame_done,
    output logic                          timeout_err,
    output logic [2:0]                    state_o
);

    localparam int FLUSH_CYCLES = flush_cycles(WAVELENGTH, PREAMBLE_LENGTH);
    localparam int ALIGN_CYCLES = align_cycles(WAVELENGTH, LOCK_HOLD);
    localparam int FLUSH_W      = cnt_width(FLUSH_CYCLES);
    localparam int SEARCH_W     = cnt_width(SEARCH_TIMEOUT);
    localparam int HOLD_W       = cnt_width(LOCK_HOLD);
    localparam int ALIGN_W      = cnt_width(ALIGN_CYCLES);

    localparam logic [FLUSH_W-1:0]  FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [ALIGN_W-1:0]  ALIGN_LAST  = ALIGN_W'(ALIGN_CYCLES - 1);

    rx_state_e           state_r;
    rx_state_e           state_next_s;
    logic [FLUSH_W-1:0]  flush_cnt_r;
    logic [SEARCH_W-1:0] search_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [ALIGN_W-1:0]  align_cnt_r;
    logic                lock_s;
    logic                timeout_s;
    logic                corr_rst_n_r;
    logic                demod_en_r;
    logic                frame_done_r;
    logic                timeout_err_r;
    logic                timer_clear_s;
    logic                timer_run_s;
    logic                timer_last_s;

    // Next-state selection; dropping enable overrides every state.
    always_comb begin
        state_next_s = state_r;
        lock_s       = 1'b0;
        timeout_s    = 1'b0;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_FLUSH;
                ST_FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        state_next_s = ST_SEARCH;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
                ST_SEARCH: begin
                    lock_s    = corr_done && (hold_cnt_r == HOLD_LAST);
                    timeout_s = (search_cnt_r == SEARCH_LAST);
                    // Lock takes precedence over a timeout landing on the same cycle.
                    if (lock_s) begin
                        state_next_s = ST_ALIGN;
                    end else if (timeout_s) begin
                        state_next_s = ST_FLUSH;
                    end else begin
                        state_next_s = ST_SEARCH;
                    end
                end
                ST_ALIGN: begin
                    if (align_cnt_r == ALIGN_LAST) begin
                        state_next_s = ST_RECEIVE;
                    end else begin
                        state_next_s = ST_ALIGN;
                    end
                end
                ST_RECEIVE: begin
                    if (timer_last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RECEIVE;
                    end
                end
                ST_DONE: state_next_s = ST_FLUSH;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register and per-state counters; each counter clears whenever its state is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            flush_cnt_r  <= {FLUSH_W{1'b0}};
            search_cnt_r <= {SEARCH_W{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
            align_cnt_r  <= {ALIGN_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            flush_cnt_r  <= (state_r == ST_FLUSH && state_next_s == ST_FLUSH)
                            ? flush_cnt_r + FLUSH_W'(1) : {FLUSH_W{1'b0}};
            search_cnt_r <= (state_r == ST_SEARCH && state_next_s == ST_SEARCH)
                            ? search_cnt_r + SEARCH_W'(1) : {SEARCH_W{1'b0}};
            hold_cnt_r   <= (state_r == ST_SEARCH && state_next_s == ST_SEARCH && corr_done)
                            ? hold_cnt_r + HOLD_W'(1) : {HOLD_W{1'b0}};
            align_cnt_r  <= (state_r == ST_ALIGN && state_next_s == ST_ALIGN)
                            ? align_cnt_r + ALIGN_W'(1) : {ALIGN_W{1'b0}};
        end
    end

    // Output flops track the state being entered so they line up with state_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_rst_n_r  <= 1'b0;
            demod_en_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            corr_rst_n_r  <= !(state_next_s == ST_IDLE || state_next_s == ST_FLUSH);
            demod_en_r    <= (state_next_s == ST_RECEIVE);
            frame_done_r  <= (state_next_s == ST_DONE);
            timeout_err_r <= timeout_s && !lock_s;
        end
    end

    assign timer_clear_s = (state_next_s != ST_RECEIVE);
    assign timer_run_s   = (state_r == ST_RECEIVE) && (state_next_s == ST_RECEIVE);

    symbol_timer #(
        .WAVELENGTH (WAVELENGTH),
        .FRAME_BITS (FRAME_BITS)
    ) u_symbol_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .strobe (bit_strobe),
        .index  (bit_index),
        .last   (timer_last_s)
    );

    assign corr_rst_n  = corr_rst_n_r;
    assign demod_en    = demod_en_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;
    assign state_o     = state_r;

endmodule
